// File: rtl/branch_resolve_unit_if.sv
// Branch request / next-PC handshake bundle between decode-fetch and branch_resolve_unit.
// master = decode/fetch side, slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int DATA_W = 16
);
  logic              br_valid;
  logic              br_ready;
  logic [1:0]        br_op;
  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] pc_next_seq;
  logic              npc_valid;
  logic              npc_ready;
  logic [DATA_W-1:0] npc;
  logic              npc_taken;

  modport master (
    output br_valid, br_op, br_target, pc_next_seq, npc_ready,
    input  br_ready, npc_valid, npc, npc_taken
  );

  modport slave (
    input  br_valid, br_op, br_target, pc_next_seq, npc_ready,
    output br_ready, npc_valid, npc, npc_taken
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Accumulator/flag register stage plus conditional branch resolver with flag scoreboard stall.
// Optional macro BR_TAKEN_COUNT_EN adds a saturating taken-branch counter output br_taken_cnt.
module branch_resolve_unit #(
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    alu_o,
  input  logic                 alu_z,
  input  logic [DATA_W-1:0]    alu_g,
  input  logic                 res_valid,
  input  logic                 acc_we,
  input  logic                 flags_we,
  input  logic                 flag_pend_set,
  branch_resolve_unit_if.slave br,
  output logic [DATA_W-1:0]    acc,
  output logic                 flag_z,
  output logic                 flag_g,
  output logic                 wait_timeout
`ifdef BR_TAKEN_COUNT_EN
  ,
  output logic [15:0]          br_taken_cnt
`endif
);

  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  localparam logic [1:0] OP_BEQ = 2'd0;
  localparam logic [1:0] OP_BNE = 2'd1;
  localparam logic [1:0] OP_BGT = 2'd2;
  localparam logic [1:0] OP_JMP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] seq_q, seq_d;
  logic [DATA_W-1:0] npc_q, npc_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] acc_q;
  logic              flagZ_q, flagG_q;
  logic              sb_q;

  logic flagWr;
  logic effZ;
  logic effG;
  logic accept;

  function automatic logic evalTaken(input logic [1:0] op, input logic z, input logic g);
    case (op)
      OP_BEQ:  evalTaken = z;
      OP_BNE:  evalTaken = ~z;
      OP_BGT:  evalTaken = g;
      default: evalTaken = 1'b1;
    endcase
  endfunction

  // A flag write in the current cycle is forwarded so a branch never waits on data already on the bus.
  assign flagWr = res_valid & flags_we;
  assign effZ   = flagWr ? alu_z    : flagZ_q;
  assign effG   = flagWr ? alu_g[0] : flagG_q;
  assign accept = br.br_valid & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      flagZ_q <= 1'b0;
      flagG_q <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      if (res_valid && acc_we) acc_q <= alu_o;
      if (flagWr) begin
        flagZ_q <= alu_z;
        flagG_q <= alu_g[0];
      end
      // A same-cycle write retires the older producer, so a new pending set wins.
      if (flag_pend_set)  sb_q <= 1'b1;
      else if (flagWr)    sb_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_BEQ;
      target_q  <= '0;
      seq_q     <= '0;
      npc_q     <= '0;
      taken_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      target_q  <= target_d;
      seq_q     <= seq_d;
      npc_q     <= npc_d;
      taken_q   <= taken_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    target_d  = target_q;
    seq_d     = seq_q;
    npc_d     = npc_q;
    taken_d   = taken_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = br.br_op;
          target_d = br.br_target;
          seq_d    = br.pc_next_seq;
          if ((br.br_op == OP_JMP) || !sb_q || flagWr) begin
            taken_d = evalTaken(br.br_op, effZ, effG);
            npc_d   = taken_d ? br.br_target : br.pc_next_seq;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flagWr) begin
          taken_d = evalTaken(op_q, effZ, effG);
          npc_d   = taken_d ? target_q : seq_q;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          taken_d   = 1'b0;
          npc_d     = seq_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (br.npc_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // br_ready is gated by rst_n so it reads low for the whole reset pulse.
  always_comb begin
    br.br_ready  = rst_n && (state_q == S_IDLE);
    br.npc_valid = (state_q == S_DONE);
    br.npc       = npc_q;
    br.npc_taken = taken_q;
    acc          = acc_q;
    flag_z       = flagZ_q;
    flag_g       = flagG_q;
    wait_timeout = timeout_q;
  end

`ifdef BR_TAKEN_COUNT_EN
  logic [15:0] takenCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      takenCnt_q <= '0;
    end else if ((state_q == S_DONE) && br.npc_ready && taken_q && (takenCnt_q != 16'hFFFF)) begin
      takenCnt_q <= takenCnt_q + 16'd1;
    end
  end

  assign br_taken_cnt = takenCnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: flags, forwarding, stall, timeout, backpressure, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_branch_resolve_unit;

  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] alu_o;
  logic              alu_z;
  logic [DATA_W-1:0] alu_g;
  logic              res_valid;
  logic              acc_we;
  logic              flags_we;
  logic              flag_pend_set;
  logic [DATA_W-1:0] acc;
  logic              flag_z;
  logic              flag_g;
  logic              wait_timeout;
`ifdef BR_TAKEN_COUNT_EN
  logic [15:0]       br_taken_cnt;
`endif

  int compared;
  int mismatched;

  branch_resolve_unit_if #(.DATA_W(DATA_W)) brIf ();

  branch_resolve_unit #(.DATA_W(DATA_W), .WAIT_MAX(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_o         (alu_o),
    .alu_z         (alu_z),
    .alu_g         (alu_g),
    .res_valid     (res_valid),
    .acc_we        (acc_we),
    .flags_we      (flags_we),
    .flag_pend_set (flag_pend_set),
    .br            (brIf),
    .acc           (acc),
    .flag_z        (flag_z),
    .flag_g        (flag_g),
    .wait_timeout  (wait_timeout)
`ifdef BR_TAKEN_COUNT_EN
    ,
    .br_taken_cnt  (br_taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic aluWrite(input logic [DATA_W-1:0] val, input logic z, input logic [DATA_W-1:0] g);
    res_valid = 1'b1; acc_we = 1'b1; flags_we = 1'b1;
    alu_o = val; alu_z = z; alu_g = g;
    tick();
    res_valid = 1'b0; acc_we = 1'b0; flags_we = 1'b0;
  endtask

  task automatic setPending();
    flag_pend_set = 1'b1;
    tick();
    flag_pend_set = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [DATA_W-1:0] tgt, input logic [DATA_W-1:0] seq);
    brIf.br_valid = 1'b1; brIf.br_op = op; brIf.br_target = tgt; brIf.pc_next_seq = seq;
    tick();
    brIf.br_valid = 1'b0;
  endtask

  task automatic consume();
    brIf.npc_ready = 1'b1;
    tick();
    brIf.npc_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if (brIf.br_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_br_ready: got %b expected 0", brIf.br_ready); end
    compared++;
    if (brIf.npc_valid !== 1'b0 || brIf.npc !== 16'h0000 || brIf.npc_taken !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_npc: got v=%b npc=%h t=%b expected 0/0000/0", brIf.npc_valid, brIf.npc, brIf.npc_taken);
    end
    compared++;
    if (acc !== 16'h0000 || flag_z !== 1'b0 || flag_g !== 1'b0 || wait_timeout !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_regs: got acc=%h z=%b g=%b to=%b expected 0000/0/0/0", acc, flag_z, flag_g, wait_timeout);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (brIf.br_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_ready: got %b expected 1", brIf.br_ready); end
  endtask

  task automatic test_beq_zero();
    aluWrite(16'h0000, 1'b1, 16'h0000);
    issue(2'd0, 16'h0040, 16'h0012);
    compared++;
    if (brIf.npc_valid !== 1'b1 || brIf.npc !== 16'h0040 || brIf.npc_taken !== 1'b1 || acc !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL beq_zero: got v=%b npc=%h t=%b acc=%h expected 1/0040/1/0000", brIf.npc_valid, brIf.npc, brIf.npc_taken, acc);
    end
    consume();
    compared++;
    if (brIf.npc_valid !== 1'b0 || brIf.br_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL beq_release: got v=%b rdy=%b expected 0/1", brIf.npc_valid, brIf.br_ready);
    end
  endtask

  task automatic test_flags();
    aluWrite(16'h1234, 1'b0, 16'h0003);
    compared++;
    if (acc !== 16'h1234 || flag_z !== 1'b0 || flag_g !== 1'b1) begin
      mismatched++; $display("[TB] FAIL flag_load: got acc=%h z=%b g=%b expected 1234/0/1", acc, flag_z, flag_g);
    end
    issue(2'd2, 16'h0100, 16'h0020);
    compared++;
    if (brIf.npc !== 16'h0100 || brIf.npc_taken !== 1'b1) begin
      mismatched++; $display("[TB] FAIL bgt_taken: got npc=%h t=%b expected 0100/1", brIf.npc, brIf.npc_taken);
    end
    consume();
    aluWrite(16'h5555, 1'b0, 16'h0002);
    issue(2'd2, 16'h0100, 16'h0024);
    compared++;
    if (brIf.npc !== 16'h0024 || brIf.npc_taken !== 1'b0 || acc !== 16'h5555) begin
      mismatched++; $display("[TB] FAIL bgt_not_taken: got npc=%h t=%b acc=%h expected 0024/0/5555", brIf.npc, brIf.npc_taken, acc);
    end
    consume();
    issue(2'd1, 16'h0200, 16'h0028);
    compared++;
    if (brIf.npc !== 16'h0200 || brIf.npc_taken !== 1'b1) begin
      mismatched++; $display("[TB] FAIL bne_taken: got npc=%h t=%b expected 0200/1", brIf.npc, brIf.npc_taken);
    end
    consume();
  endtask

  task automatic test_stall();
    setPending();
    issue(2'd1, 16'h0300, 16'h0030);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (brIf.br_ready !== 1'b0 || brIf.npc_valid !== 1'b0) begin
        mismatched++; $display("[TB] FAIL stall_wait%0d: got rdy=%b v=%b expected 0/0", i, brIf.br_ready, brIf.npc_valid);
      end
      tick();
    end
    res_valid = 1'b1; flags_we = 1'b1; alu_z = 1'b1; alu_g = 16'h0000;
    tick();
    res_valid = 1'b0; flags_we = 1'b0;
    compared++;
    if (brIf.npc_valid !== 1'b1 || brIf.npc !== 16'h0030 || brIf.npc_taken !== 1'b0 || flag_z !== 1'b1 || wait_timeout !== 1'b0) begin
      mismatched++; $display("[TB] FAIL stall_resolve: got v=%b npc=%h t=%b z=%b to=%b expected 1/0030/0/1/0",
                             brIf.npc_valid, brIf.npc, brIf.npc_taken, flag_z, wait_timeout);
    end
    consume();
  endtask

  task automatic test_accept_forward();
    aluWrite(16'h0007, 1'b0, 16'h0000);
    setPending();
    res_valid = 1'b1; flags_we = 1'b1; alu_z = 1'b1; alu_g = 16'h0000;
    issue(2'd0, 16'h0400, 16'h0040);
    res_valid = 1'b0; flags_we = 1'b0;
    compared++;
    if (brIf.npc_valid !== 1'b1 || brIf.npc !== 16'h0400 || brIf.npc_taken !== 1'b1) begin
      mismatched++; $display("[TB] FAIL accept_forward: got v=%b npc=%h t=%b expected 1/0400/1", brIf.npc_valid, brIf.npc, brIf.npc_taken);
    end
    consume();
  endtask

  task automatic test_timeout_jmp();
    int n;
    setPending();
    issue(2'd0, 16'h0500, 16'h0050);
    compared++;
    if (wait_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_early: got %b expected 0", wait_timeout); end
    n = 0;
    while (brIf.npc_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (n !== 15) begin mismatched++; $display("[TB] FAIL timeout_cycles: got %0d expected 15", n); end
    compared++;
    if (wait_timeout !== 1'b1 || brIf.npc !== 16'h0050 || brIf.npc_taken !== 1'b0) begin
      mismatched++; $display("[TB] FAIL timeout_resolve: got to=%b npc=%h t=%b expected 1/0050/0", wait_timeout, brIf.npc, brIf.npc_taken);
    end
    consume();
    issue(2'd3, 16'h0600, 16'h0060);
    compared++;
    if (brIf.npc_valid !== 1'b1 || brIf.npc !== 16'h0600 || brIf.npc_taken !== 1'b1) begin
      mismatched++; $display("[TB] FAIL jmp_pending: got v=%b npc=%h t=%b expected 1/0600/1", brIf.npc_valid, brIf.npc, brIf.npc_taken);
    end
    consume();
    compared++;
    if (wait_timeout !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_sticky: got %b expected 1", wait_timeout); end
  endtask

  task automatic test_back_to_back_hold();
    aluWrite(16'h00AA, 1'b1, 16'h0000);
    issue(2'd0, 16'h0700, 16'h0070);
    brIf.br_valid = 1'b1; brIf.br_op = 2'd3; brIf.br_target = 16'h0BAD; brIf.pc_next_seq = 16'h0BAE;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (brIf.npc_valid !== 1'b1 || brIf.npc !== 16'h0700 || brIf.npc_taken !== 1'b1 || brIf.br_ready !== 1'b0) begin
        mismatched++; $display("[TB] FAIL hold%0d: got v=%b npc=%h t=%b rdy=%b expected 1/0700/1/0",
                               i, brIf.npc_valid, brIf.npc, brIf.npc_taken, brIf.br_ready);
      end
      tick();
    end
    brIf.br_valid = 1'b0;
    consume();
`ifdef BR_TAKEN_COUNT_EN
    compared++;
    if (br_taken_cnt !== 16'd6) begin mismatched++; $display("[TB] FAIL taken_cnt: got %0d expected 6", br_taken_cnt); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    setPending();
    issue(2'd1, 16'h0800, 16'h0080);
    tick();
    compared++;
    if (brIf.npc_valid !== 1'b0 || brIf.br_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL mid_wait: got v=%b rdy=%b expected 0/0", brIf.npc_valid, brIf.br_ready);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (brIf.npc_valid !== 1'b0 || brIf.br_ready !== 1'b0 || brIf.npc !== 16'h0000 || brIf.npc_taken !== 1'b0) begin
      mismatched++; $display("[TB] FAIL async_reset_npc: got v=%b rdy=%b npc=%h t=%b expected 0/0/0000/0",
                             brIf.npc_valid, brIf.br_ready, brIf.npc, brIf.npc_taken);
    end
    compared++;
    if (acc !== 16'h0000 || flag_z !== 1'b0 || flag_g !== 1'b0 || wait_timeout !== 1'b0) begin
      mismatched++; $display("[TB] FAIL async_reset_regs: got acc=%h z=%b g=%b to=%b expected 0000/0/0/0", acc, flag_z, flag_g, wait_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    compared++;
    if (brIf.npc_valid !== 1'b0 || brIf.br_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL discard_branch: got v=%b rdy=%b expected 0/1", brIf.npc_valid, brIf.br_ready);
    end
    issue(2'd0, 16'h0900, 16'h0090);
    compared++;
    if (brIf.npc_valid !== 1'b1 || brIf.npc !== 16'h0090 || brIf.npc_taken !== 1'b0) begin
      mismatched++; $display("[TB] FAIL sb_cleared: got v=%b npc=%h t=%b expected 1/0090/0", brIf.npc_valid, brIf.npc, brIf.npc_taken);
    end
    consume();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    alu_o = '0; alu_z = 1'b0; alu_g = '0;
    res_valid = 1'b0; acc_we = 1'b0; flags_we = 1'b0; flag_pend_set = 1'b0;
    brIf.br_valid = 1'b0; brIf.br_op = 2'd0; brIf.br_target = '0; brIf.pc_next_seq = '0; brIf.npc_ready = 1'b0;

    test_reset();
    test_beq_zero();
    test_flags();
    test_stall();
    test_accept_forward();
    test_timeout_jmp();
    test_back_to_back_hold();
    test_reset_mid_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
